// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store alignment between EX/MEM and a word-addressed data memory.
// Loads are combinational extract + extend. SW writes in one cycle. SB/SH use a
// two-cycle read-modify-write: the first cycle stalls and captures the old word, and
// the second cycle writes the merged word. Misaligned or illegal accesses are flagged
// and suppressed.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] dm_data_read,
  output logic        dm_memrw,
  output logic [31:0] dm_address,
  output logic [31:0] dm_data_write,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misaligned
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] buf_word_q, buf_word_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic [2:0]  buf_f3_q, buf_f3_d;
  logic [15:0] buf_data_q, buf_data_d;

  // Stores accept only B/H/W; the unsigned encodings make sense for loads only.
  function automatic logic access_misaligned(input logic is_store, input logic [2:0] f3,
                                             input logic [1:0] lo);
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = lo[0];
      F3_W:    bad = (lo != 2'b00);
      F3_BU:   bad = is_store;
      F3_HU:   bad = is_store | lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h000000, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0000, h};
      F3_W:    r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Replace one byte or halfword lane of the captured word with the store data.
  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] lo, input logic [15:0] data);
    logic [31:0] m;
    m = word;
    case (f3)
      F3_B: begin
        case (lo)
          2'b00:   m[7:0]   = data[7:0];
          2'b01:   m[15:8]  = data[7:0];
          2'b10:   m[23:16] = data[7:0];
          2'b11:   m[31:24] = data[7:0];
          default: m = word;
        endcase
      end
      F3_H: begin
        if (lo[1]) begin
          m[31:16] = data;
        end else begin
          m[15:0] = data;
        end
      end
      default: m = word;
    endcase
    return m;
  endfunction

  // Next-state, buffer capture and all outputs; reset forces outputs quiet at once.
  always_comb begin
    state_d       = state_q;
    buf_word_d    = buf_word_q;
    buf_addr_d    = buf_addr_q;
    buf_f3_d      = buf_f3_q;
    buf_data_d    = buf_data_q;
    dm_memrw      = 1'b0;
    dm_address    = addr;
    dm_data_write = 32'h0000_0000;
    load_data     = 32'h0000_0000;
    stall         = 1'b0;
    misaligned    = 1'b0;
    if (rst) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_write) begin
            if (access_misaligned(1'b1, funct3, addr[1:0])) begin
              misaligned = 1'b1;
            end else if (funct3 == F3_W) begin
              dm_memrw      = 1'b1;
              dm_data_write = store_data;
            end else begin
              stall      = 1'b1;
              buf_word_d = dm_data_read;
              buf_addr_d = addr;
              buf_f3_d   = funct3;
              buf_data_d = store_data[15:0];
              state_d    = RMW_WR;
            end
          end else if (mem_read) begin
            if (access_misaligned(1'b0, funct3, addr[1:0])) begin
              misaligned = 1'b1;
            end else begin
              load_data = extract_load(dm_data_read, funct3, addr[1:0]);
            end
          end else begin
            state_d = IDLE;
          end
        end
        RMW_WR: begin
          dm_memrw      = 1'b1;
          dm_address    = buf_addr_q;
          dm_data_write = merge_store(buf_word_q, buf_f3_q, buf_addr_q[1:0], buf_data_q);
          state_d       = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and read-modify-write holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_word_q <= 32'h0000_0000;
      buf_addr_q <= 32'h0000_0000;
      buf_f3_q   <= 3'b000;
      buf_data_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      buf_word_q <= buf_word_d;
      buf_addr_q <= buf_addr_d;
      buf_f3_q   <= buf_f3_d;
      buf_data_q <= buf_data_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed scenarios plus randomized accesses checked
// against a byte-level reference model of memory and the RV32 load/store rules.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, dm_data_read;
  logic        dm_memrw;
  logic [31:0] dm_address, dm_data_write, load_data;
  logic        stall, misaligned;

  logic [31:0] tb_mem  [256];
  logic [31:0] ref_mem [256];

  int n_checks;
  int n_fail;

  logic        o_mis, o_stall0, o_memrw0, o_stall1, o_memrw1;
  logic [31:0] o_load, o_wdata0, o_wdata1, o_addr1;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .store_data(store_data), .dm_data_read(dm_data_read),
    .dm_memrw(dm_memrw), .dm_address(dm_address), .dm_data_write(dm_data_write),
    .load_data(load_data), .stall(stall), .misaligned(misaligned)
  );

  // Data memory: combinational read, word 0 reads as zero.
  assign dm_data_read = (dm_address[9:2] == 8'd0) ? 32'h0 : tb_mem[dm_address[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: sample the write request mid-cycle, apply it at the rising edge.
  task automatic tick();
    logic w;
    logic [7:0] wi;
    logic [31:0] wd;
    @(negedge clk);
    w = dm_memrw; wi = dm_address[9:2]; wd = dm_data_write;
    @(posedge clk);
    if (w && !rst) tb_mem[wi] = wd;
    #1;
  endtask

  // Drive one access and observe it; a stalled access is held for its second cycle.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = d;
    #1;
    o_mis = misaligned; o_stall0 = stall; o_memrw0 = dm_memrw;
    o_load = load_data; o_wdata0 = dm_data_write;
    tick();
    o_stall1 = 1'b0; o_memrw1 = 1'b0; o_wdata1 = 32'h0; o_addr1 = 32'h0;
    if (o_stall0) begin
      o_stall1 = stall; o_memrw1 = dm_memrw; o_wdata1 = dm_data_write; o_addr1 = dm_address;
      tick();
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  function automatic logic ref_mis(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (st) begin
      if (f3 > 3'd2) return 1'b1;
    end else begin
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    end
    sz = 1 << f3[1:0];
    return (int'(a[1:0]) % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [31:0] a);
    longint unsigned v;
    int nb;
    nb = 8 << f3[1:0];
    if (nb == 32) return word;
    v = (longint'(word) >> (8 * a[1:0])) & ((64'd1 << nb) - 64'd1);
    if (!f3[2] && v >= (64'd1 << (nb - 1))) v = v - (64'd1 << nb);
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] d);
    longint unsigned m, r;
    int nb, sh;
    nb = 8 << f3[1:0];
    sh = 8 * a[1:0];
    m = ((64'd1 << nb) - 64'd1) << sh;
    r = (longint'(old) & ~m) | ((longint'(d) << sh) & m);
    return r[31:0];
  endfunction

  function automatic logic [31:0] ref_read(input logic [7:0] idx);
    return (idx == 8'd0) ? 32'h0 : ref_mem[idx];
  endfunction

  task automatic test_reset();
    mem_read = 1'b1; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h70; store_data = 32'hDEAD_BEEF;
    #2;
    n_checks += 5;
    if (dm_memrw !== 1'b0) begin n_fail++; $display("FAIL reset_memrw: got %b expected 0", dm_memrw); end
    if (dm_data_write !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", dm_data_write); end
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    if (misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b expected 0", misaligned); end
    if (load_data !== 32'h0) begin n_fail++; $display("FAIL reset_load: got %h expected 0", load_data); end
    funct3 = 3'b000;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_sb_stall: got %b expected 0", stall); end
    mem_read = 1'b0; mem_write = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] as  [5] = '{32'h10, 32'h11, 32'h12, 32'h12, 32'h10};
    logic [31:0] es  [5] = '{32'hFFFF_FFA5, 32'h0000_00F0, 32'hFFFF_8000, 32'h0000_8000, 32'h8000_F0A5};
    tb_mem[4] = 32'h8000_F0A5; ref_mem[4] = 32'h8000_F0A5;
    for (int i = 0; i < 5; i++) begin
      run_access(1'b1, 1'b0, f3s[i], as[i], 32'h0);
      n_checks += 2;
      if (o_load !== es[i]) begin n_fail++; $display("FAIL load_%0d: got %h expected %h", i, o_load, es[i]); end
      if (o_stall0 !== 1'b0) begin n_fail++; $display("FAIL load_stall_%0d: got %b expected 0", i, o_stall0); end
    end
  endtask

  task automatic test_sb();
    tb_mem[8] = 32'h1122_3344; ref_mem[8] = 32'h1122_3344;
    run_access(1'b0, 1'b1, 3'b000, 32'h21, 32'h0000_005A);
    n_checks += 5;
    if (o_stall0 !== 1'b1) begin n_fail++; $display("FAIL sb_stall0: got %b expected 1", o_stall0); end
    if (o_memrw0 !== 1'b0) begin n_fail++; $display("FAIL sb_memrw0: got %b expected 0", o_memrw0); end
    if (o_stall1 !== 1'b0) begin n_fail++; $display("FAIL sb_stall1: got %b expected 0", o_stall1); end
    if (o_memrw1 !== 1'b1) begin n_fail++; $display("FAIL sb_memrw1: got %b expected 1", o_memrw1); end
    if (o_wdata1 !== 32'h1122_5A44) begin n_fail++; $display("FAIL sb_wdata: got %h expected 11225a44", o_wdata1); end
    ref_mem[8] = 32'h1122_5A44;
    run_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    n_checks++;
    if (o_load !== 32'h1122_5A44) begin n_fail++; $display("FAIL sb_reload: got %h expected 11225a44", o_load); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    tb_mem[9] = 32'hAAAA_AAAA; ref_mem[9] = 32'hAAAA_AAAA;
    run_access(1'b0, 1'b1, 3'b001, 32'h26, 32'h0000_BEEF);
    pat[3] = o_stall0; pat[2] = o_stall1;
    n_checks++;
    if (o_wdata1 !== 32'hBEEF_AAAA) begin n_fail++; $display("FAIL sh_wdata: got %h expected beefaaaa", o_wdata1); end
    run_access(1'b0, 1'b1, 3'b000, 32'h24, 32'h0000_0000);
    pat[1] = o_stall0; pat[0] = o_stall1;
    n_checks += 2;
    if (pat !== 4'b1010) begin n_fail++; $display("FAIL b2b_stall_pattern: got %b expected 1010", pat); end
    if (tb_mem[9] !== 32'hBEEF_AA00) begin n_fail++; $display("FAIL b2b_word: got %h expected beefaa00", tb_mem[9]); end
    ref_mem[9] = 32'hBEEF_AA00;
  endtask

  task automatic test_misaligned();
    run_access(1'b1, 1'b0, 3'b010, 32'h31, 32'h0);
    n_checks += 2;
    if (o_mis !== 1'b1) begin n_fail++; $display("FAIL lw_mis: got %b expected 1", o_mis); end
    if (o_load !== 32'h0) begin n_fail++; $display("FAIL lw_mis_load: got %h expected 0", o_load); end
    tb_mem[12] = 32'h0BAD_F00D; ref_mem[12] = 32'h0BAD_F00D;
    run_access(1'b0, 1'b1, 3'b001, 32'h33, 32'h0000_1234);
    n_checks += 4;
    if (o_mis !== 1'b1) begin n_fail++; $display("FAIL sh_mis: got %b expected 1", o_mis); end
    if (o_memrw0 !== 1'b0 || dm_memrw !== 1'b0) begin n_fail++; $display("FAIL sh_mis_memrw: got %b/%b expected 0/0", o_memrw0, dm_memrw); end
    if (o_stall0 !== 1'b0) begin n_fail++; $display("FAIL sh_mis_stall: got %b expected 0", o_stall0); end
    if (tb_mem[12] !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL sh_mis_mem: got %h expected 0badf00d", tb_mem[12]); end
    run_access(1'b0, 1'b1, 3'b100, 32'h40, 32'h0000_00FF);
    n_checks += 2;
    if (o_mis !== 1'b1) begin n_fail++; $display("FAIL sbu_mis: got %b expected 1", o_mis); end
    if (o_stall0 !== 1'b0 || o_memrw0 !== 1'b0) begin n_fail++; $display("FAIL sbu_suppress: got %b/%b expected 0/0", o_stall0, o_memrw0); end
  endtask

  task automatic test_reset_in_rmw();
    tb_mem[20] = 32'hCAFE_F00D; ref_mem[20] = 32'hCAFE_F00D;
    mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b000; addr = 32'h51; store_data = 32'h77;
    #1;
    tick();
    n_checks++;
    if (dm_memrw !== 1'b1) begin n_fail++; $display("FAIL rmw_entry_memrw: got %b expected 1", dm_memrw); end
    rst = 1'b1;
    #1;
    n_checks += 2;
    if (dm_memrw !== 1'b0) begin n_fail++; $display("FAIL rst_rmw_memrw: got %b expected 0", dm_memrw); end
    if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_rmw_stall: got %b expected 0", stall); end
    tick();
    rst = 1'b0;
    #1;
    n_checks += 3;
    if (tb_mem[20] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rst_rmw_mem: got %h expected cafef00d", tb_mem[20]); end
    if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_rmw_idle_stall: got %b expected 1", stall); end
    if (dm_memrw !== 1'b0) begin n_fail++; $display("FAIL rst_rmw_idle_memrw: got %b expected 0", dm_memrw); end
    mem_write = 1'b0;
    tick();
  endtask

  task automatic test_both_rw();
    run_access(1'b1, 1'b1, 3'b010, 32'h60, 32'h1357_2468);
    n_checks += 4;
    if (o_memrw0 !== 1'b1) begin n_fail++; $display("FAIL rw_memrw: got %b expected 1", o_memrw0); end
    if (o_wdata0 !== 32'h1357_2468) begin n_fail++; $display("FAIL rw_wdata: got %h expected 13572468", o_wdata0); end
    if (o_load !== 32'h0) begin n_fail++; $display("FAIL rw_load: got %h expected 0", o_load); end
    if (tb_mem[24] !== 32'h1357_2468) begin n_fail++; $display("FAIL rw_mem: got %h expected 13572468", tb_mem[24]); end
    ref_mem[24] = 32'h1357_2468;
  endtask

  task automatic test_random();
    logic [2:0]  lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic        rd, wr, mis_e, sub, sw;
    logic [2:0]  f3;
    logic [31:0] a, d, load_e, new_word;
    logic [7:0]  idx;
    int kind;
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 3);
      wr = (kind >= 2);
      rd = (kind == 1) || (wr && ($urandom_range(0, 3) == 0));
      f3 = wr ? 3'($urandom_range(0, 7)) : lf3[$urandom_range(0, 4)];
      a = $urandom;
      d = $urandom;
      idx = a[9:2];
      mis_e = (rd || wr) ? ref_mis(wr, f3, a) : 1'b0;
      sub = wr && !mis_e && (f3 != 3'd2);
      sw = wr && !mis_e && (f3 == 3'd2);
      load_e = (!wr && rd && !mis_e) ? ref_load(ref_read(idx), f3, a) : 32'h0;
      new_word = ref_store(ref_read(idx), f3, a, d);
      run_access(rd, wr, f3, a, d);
      n_checks += 5;
      if (o_mis !== mis_e) begin n_fail++; $display("FAIL rnd_mis[%0d]: got %b expected %b", i, o_mis, mis_e); end
      if (o_stall0 !== sub) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %b expected %b", i, o_stall0, sub); end
      if (o_memrw0 !== sw) begin n_fail++; $display("FAIL rnd_memrw[%0d]: got %b expected %b", i, o_memrw0, sw); end
      if (o_load !== load_e) begin n_fail++; $display("FAIL rnd_load[%0d]: got %h expected %h", i, o_load, load_e); end
      if (sub) begin
        if (o_memrw1 !== 1'b1 || o_stall1 !== 1'b0 || o_wdata1 !== new_word || o_addr1[9:2] !== idx) begin
          n_fail++;
          $display("FAIL rnd_rmw[%0d]: got memrw=%b stall=%b data=%h idx=%h expected 1 0 %h %h",
                   i, o_memrw1, o_stall1, o_wdata1, o_addr1[9:2], new_word, idx);
        end
      end else if (sw) begin
        if (o_wdata0 !== d) begin n_fail++; $display("FAIL rnd_sw_data[%0d]: got %h expected %h", i, o_wdata0, d); end
      end
      if (sub || sw) ref_mem[idx] = new_word;
      if (tb_mem[idx] !== ref_mem[idx]) begin
        n_fail++;
        $display("FAIL rnd_mem[%0d]: got %h expected %h", i, tb_mem[idx], ref_mem[idx]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000; addr = 32'h0; store_data = 32'h0;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    test_reset();
    test_loads();
    test_sb();
    test_back_to_back();
    test_misaligned();
    test_reset_in_rmw();
    test_both_rw();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
